// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared defaults and mode encodings for the N:1 arbitrated mux.
package mux_pkg;

    localparam int   DEFAULT_WIDTH = 32;
    localparam int   DEFAULT_NCH   = 4;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin search over NCH requests with a rotating priority pointer.
module rr_arbiter #(
    parameter int NCH  = 4,
    parameter int SELW = $clog2(NCH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NCH-1:0]  req,
    input  logic            advance,
    output logic [SELW-1:0] grant,
    output logic            grant_valid
);

    logic [SELW-1:0] ptr;

    // Scan downward so the lowest offset from ptr is written last and wins.
    always_comb begin
        int idx;
        grant       = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int k = NCH - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NCH) begin
                idx = idx - NCH;
            end
            if (req[idx]) begin
                grant       = SELW'(idx);
                grant_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance && grant_valid) begin
            ptr <= (grant == SELW'(NCH - 1)) ? '0 : grant + 1'b1;
        end
    end

endmodule

// File: rtl/mux_n_to_1_arb.sv
// rtl/mux_n_to_1_arb.sv - N:1 registered mux, explicit select or round-robin (MUX_RR_ARB_EN).
module mux_n_to_1_arb
    import mux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int NCH   = DEFAULT_NCH,
    parameter int SELW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    input  logic [SELW-1:0]      sel_i,
    input  logic                 mode_rr,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_ch,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic            load_en;
    logic            xfer;
    logic            rr_mode;
    logic            rr_valid;
    logic [SELW-1:0] rr_grant;
    logic            gnt_ok;
    logic [SELW-1:0] gnt;

    assign load_en = !out_valid || out_ready;

`ifdef MUX_RR_ARB_EN
    assign rr_mode = (mode_rr == MODE_RR);

    rr_arbiter #(
        .NCH  (NCH),
        .SELW (SELW)
    ) u_rr_arbiter (
        .clk         (clk),
        .rst         (rst),
        .req         (in_valid),
        .advance     (xfer && rr_mode),
        .grant       (rr_grant),
        .grant_valid (rr_valid)
    );
`else
    logic unused_mode_rr;
    assign unused_mode_rr = mode_rr;
    assign rr_mode        = 1'b0;
    assign rr_grant       = '0;
    assign rr_valid       = 1'b0;
`endif

    // Explicit mode grants sel_i even when it is not requesting, so its ready is visible.
    always_comb begin
        if (rr_mode) begin
            gnt    = rr_grant;
            gnt_ok = rr_valid;
        end else begin
            gnt    = sel_i;
            gnt_ok = ({1'b0, sel_i} < (SELW + 1)'(NCH));
        end
    end

    assign xfer     = !rst && load_en && gnt_ok && in_valid[gnt];
    assign in_ready = (!rst && load_en && gnt_ok) ? (NCH'(1) << gnt) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else if (load_en) begin
            out_valid <= xfer;
            if (xfer) begin
                out_data <= in_data[int'(gnt) * WIDTH +: WIDTH];
                out_ch   <= gnt;
            end
        end
    end

endmodule

// File: tb/tb_mux_n_to_1_arb.sv
// tb/tb_mux_n_to_1_arb.sv - scoreboard bench for mux_n_to_1_arb (honours MUX_RR_ARB_EN).
module tb_mux_n_to_1_arb;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] in_data;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic [1:0]   sel_i;
    logic         mode_rr;
    logic [31:0]  out_data;
    logic [1:0]   out_ch;
    logic         out_valid;
    logic         out_ready;

    logic [95:0]  in_data3;
    logic [2:0]   in_valid3;
    logic [2:0]   in_ready3;
    logic [1:0]   sel3;
    logic [31:0]  out_data3;
    logic [1:0]   out_ch3;
    logic         out_valid3;
    logic         out_ready3;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  ch;
    } exp_t;
    exp_t sbq[$];

    bit   m_valid = 1'b0;
    int   m_ptr   = 0;

    always #5 clk = ~clk;

    mux_n_to_1_arb #(.WIDTH(32), .NCH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel_i     (sel_i),
        .mode_rr   (mode_rr),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    mux_n_to_1_arb #(.WIDTH(32), .NCH(3)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .sel_i     (sel3),
        .mode_rr   (1'b0),
        .out_data  (out_data3),
        .out_ch    (out_ch3),
        .out_valid (out_valid3),
        .out_ready (out_ready3)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: arbitration rules evaluated from the current inputs each cycle.
    always @(negedge clk) begin
        bit rr, le, gok, tx;
        int g;
        logic [3:0] exp_rdy;
`ifdef MUX_RR_ARB_EN
        rr = mode_rr;
`else
        rr = 1'b0;
`endif
        le  = !m_valid || out_ready;
        gok = 1'b0;
        g   = 0;
        if (rr) begin
            for (int k = 0; k < 4 && !gok; k++) begin
                if (in_valid[(m_ptr + k) % 4]) begin
                    g   = (m_ptr + k) % 4;
                    gok = 1'b1;
                end
            end
        end else begin
            g   = int'(sel_i);
            gok = 1'b1;
        end
        exp_rdy = (!rst && le && gok) ? (4'd1 << g) : 4'd0;
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        if (rst) begin
            m_valid = 1'b0;
            m_ptr   = 0;
            sbq.delete();
        end else if (le) begin
            tx      = gok && in_valid[g];
            m_valid = tx;
            if (tx) begin
                sbq.push_back('{d: in_data[g*32 +: 32], ch: 2'(g)});
                if (rr) m_ptr = (g + 1) % 4;
            end
        end
    end

    // Monitor: held word must match the oldest expected entry until it is accepted.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_word: got data %0h ch %0d expected none", out_data, out_ch);
            end else begin
                chk("out_data", 64'(out_data), 64'(sbq[0].d));
                chk("out_ch", 64'(out_ch), 64'(sbq[0].ch));
                if (out_ready) void'(sbq.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        in_data    = '0;
        in_valid   = '0;
        sel_i      = '0;
        mode_rr    = 1'b0;
        out_ready  = 1'b0;
        in_data3   = '0;
        in_valid3  = '0;
        sel3       = '0;
        out_ready3 = 1'b0;
        repeat (2) step();
        @(negedge clk);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_data", 64'(out_data), 64'd0);
        chk("reset_out_ch", 64'(out_ch), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd0);

        step();
        rst             = 1'b0;
        sel_i           = 2'd2;
        in_valid        = 4'b0100;
        in_data[64 +: 32] = 32'hDEAD_BEEF;
        out_ready       = 1'b1;
        @(negedge clk);
        chk("explicit_in_ready", 64'(in_ready), 64'h4);
        step();
        in_valid = '0;
        @(negedge clk);
        chk("explicit_out_data", 64'(out_data), 64'hDEAD_BEEF);
        chk("explicit_out_ch", 64'(out_ch), 64'd2);
        chk("explicit_out_valid", 64'(out_valid), 64'd1);

        for (int i = 0; i < 600; i++) begin
            step();
            for (int c = 0; c < 4; c++) in_data[c*32 +: 32] = $urandom;
            in_valid  = 4'($urandom);
            sel_i     = 2'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            if (i % 16 == 0) mode_rr = 1'($urandom);
            rst = ($urandom_range(0, 79) == 0);
        end

`ifdef MUX_RR_ARB_EN
        step();
        rst = 1'b1;
        step();
        rst       = 1'b0;
        mode_rr   = 1'b1;
        in_valid  = 4'hF;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            @(negedge clk);
            chk("rr_fair_ch", 64'(out_ch), 64'(i % 4));
            chk("rr_fair_valid", 64'(out_valid), 64'd1);
        end
`endif

        step();
        rst       = 1'b0;
        mode_rr   = 1'b0;
        sel_i     = 2'd1;
        in_valid  = 4'b0010;
        in_data[32 +: 32] = 32'h1234_5678;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_out_data", 64'(out_data), 64'h1234_5678);
            step();
        end
        rst = 1'b1;
        step();
        @(negedge clk);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_out_data", 64'(out_data), 64'd0);
        chk("midrst_out_ch", 64'(out_ch), 64'd0);
        step();
        rst      = 1'b0;
        in_valid = '0;

        in_data3   = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        in_valid3  = 3'b111;
        sel3       = 2'd0;
        out_ready3 = 1'b1;
        step();
        sel3       = 2'd3;
        out_ready3 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("badsel_in_ready_stall", 64'(in_ready3), 64'd0);
            chk("badsel_held_valid", 64'(out_valid3), 64'd1);
            chk("badsel_held_data", 64'(out_data3), 64'h1111_1111);
            step();
        end
        out_ready3 = 1'b1;
        @(negedge clk);
        chk("badsel_in_ready_drain", 64'(in_ready3), 64'd0);
        step();
        @(negedge clk);
        chk("badsel_out_valid_drained", 64'(out_valid3), 64'd0);

        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mux_n_to_1_arb.md
MUX_N_TO_1_ARB -- requirements
Module: mux_n_to_1_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width per channel.
REQ-002 SHALL have parameter NCH, default 4, channel count (2..16).
REQ-003 SHALL have parameter SELW, default $clog2(NCH), select/channel-index width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_data  input  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 SHALL have port in_valid  input  NCH  per-channel request.
REQ-008 SHALL have port in_ready  output  NCH  per-channel accept; combinational.
REQ-009 SHALL have port sel_i  input  SELW  explicit channel select.
REQ-010 SHALL have port mode_rr  input  1  0 = explicit select, 1 = round-robin.
REQ-011 SHALL have port out_data  output  WIDTH  registered selected data.
REQ-012 SHALL have port out_ch  output  SELW  index of the channel held in out_data.
REQ-013 SHALL have port out_valid  output  1  output register holds a word.
REQ-014 SHALL have port out_ready  input  1  downstream accept.

Function
REQ-015 load_en SHALL equal (!out_valid || out_ready).
REQ-016 Explicit mode: the grant channel SHALL be sel_i; a transfer SHALL occur when in_valid[sel_i] && load_en.
REQ-017 sel_i >= NCH SHALL produce no grant; all in_ready SHALL be 0.
REQ-018 Round-robin mode: the grant SHALL be the first valid channel found searching upward from pointer ptr, wrapping NCH-1 to 0.
REQ-019 On an RR transfer, ptr SHALL become (grant+1) mod NCH; without a transfer, ptr SHALL hold.
REQ-020 in_ready SHALL be 1 only on the granted channel and only when load_en=1; all other bits SHALL be 0.
REQ-021 On a transfer, out_data/out_ch SHALL load the granted word/index next cycle; out_valid SHALL become 1 (latency 1 cycle).
REQ-022 With load_en=1 and no grant, out_valid SHALL become 0.
REQ-023 While out_valid && !out_ready, out_data, out_ch and out_valid SHALL hold stable.
REQ-024 Simultaneous out_ready and a new grant SHALL give back-to-back transfers with no bubble (full throughput).
REQ-025 A mode_rr change SHALL take effect at the next arbitration; ptr SHALL be retained across changes.

Reset
REQ-026 On rst=1 at a clock edge: out_valid=0, out_data=0, out_ch=0, ptr=0; in_ready SHALL be 0 while rst=1.
REQ-027 Reset mid-transfer SHALL discard the held word; no transfer SHALL be signalled in that cycle.

Configuration
REQ-028 Macro MUX_RR_ARB_EN defined: round-robin logic and ptr SHALL be present, and mode_rr SHALL be honoured.
REQ-029 Macro MUX_RR_ARB_EN undefined: mode_rr SHALL be ignored, the block SHALL operate in explicit mode only, and no ptr register SHALL exist.

Structure
REQ-030 Shared package mux_pkg SHALL hold DEFAULT_WIDTH=32, DEFAULT_NCH=4, and mode constants MODE_SEL=1'b0 and MODE_RR=1'b1.
REQ-031 Round-robin search plus ptr SHALL live in sub-module rr_arbiter (inputs: req[NCH], advance; outputs: grant index, grant_valid), instantiated only under MUX_RR_ARB_EN.

Verification
REQ-032 Explicit: NCH=4, sel_i=2, in_valid=4'b0100, in_data ch2=32'hDEAD_BEEF, out_ready=1 -> in_ready=4'b0100; next cycle out_data=DEADBEEF, out_ch=2, out_valid=1.
REQ-033 Backpressure: out_valid=1, out_ready=0 for 3 cycles, ch1 valid -> in_ready=0 and outputs stable for all 3 cycles; transfer occurs in the cycle after out_ready returns to 1.
REQ-034 RR fairness: mode_rr=1, all in_valid=1, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3 with no bubbles.
REQ-035 RR skip and wrap: ptr=3, in_valid=4'b0010 -> grant ch1, then ptr=2; next with in_valid=4'b0001 -> grant ch0.
REQ-036 Invalid select: NCH=3, sel_i=3, in_valid=3'b111 -> in_ready=0; out_valid falls to 0 after the held word drains.
REQ-037 Reset mid-stream: rst=1 while out_valid=1 and out_ready=0 -> next cycle out_valid=0, out_data=0, out_ch=0; the RR sequence restarts at ch0.
